// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the three-requester datapath port arbiter:
// state encoding, mux select codes and requester indices.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SEL_R0 = 2'b00;
  localparam logic [1:0] SEL_R1 = 2'b01;
  localparam logic [1:0] SEL_R2 = 2'b10;

  localparam logic [1:0] REQ_IFETCH = 2'd0;
  localparam logic [1:0] REQ_LSU    = 2'd1;
  localparam logic [1:0] REQ_EXT    = 2'd2;

  // Successor of a requester index in the wrapping 0,1,2 order.
  function automatic logic [1:0] next_idx3(input logic [1:0] idx);
    return (idx == REQ_EXT) ? REQ_IFETCH : idx + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational round-robin picker: first requesting index searched
// upward from the one after the last owner, wrapping over three requesters.
module rr_pick3
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0     = next_idx3(last);
    c1     = next_idx3(c0);
    c2     = next_idx3(c1);
    valid  = |req;
    winner = SEL_R0;
    if (req[c0])      winner = c0;
    else if (req[c1]) winner = c1;
    else if (req[c2]) winner = c2;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner arbitration of the shared 16-bit port with bounded hold
// time and a dead turnaround cycle between owners; drives the mux3 select.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] done,
  output logic [2:0] gnt,
  output logic [1:0] s,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       s_q, s_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] win;
  logic       win_vld;
  logic       own_done, own_req, expire;

  rr_pick3 u_pick (
    .req    (req),
    .last   (last_q),
    .winner (win),
    .valid  (win_vld)
  );

  // While a grant is active the owner is always the last winner.
  always_comb begin
    own_done = done[last_q];
    own_req  = req[last_q];
    expire   = (HOLD_MAX != 0) && (cnt_q == HOLD_LIM);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    s_d       = s_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = onehot3(win);
          s_d     = win;
          busy_d  = 1'b1;
          last_d  = win;
          cnt_d   = CNT_ONE;
        end
      end
      GRANT: begin
        if (own_done || !own_req || expire) begin
          state_d   = TURN;
          gnt_d     = 3'b000;
          busy_d    = 1'b0;
          timeout_d = expire && !own_done;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TURN: begin
        // s is left untouched so the mux output stays stable.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 3'b000;
      s_q       <= SEL_R0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= REQ_EXT;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      s_q       <= s_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign s       = s_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a cycle model pushes the expected
// registered outputs per driven cycle, popped and compared after the edge.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, done, gnt;
  logic [1:0] s;
  logic       busy, timeout;
  logic [2:0] req_u, done_u, gnt_u;
  logic [1:0] s_u;
  logic       busy_u, timeout_u;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] s;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb[$];

  // Reference model state (HOLD_MAX = 8 instance)
  localparam int M_HOLD = 8;
  int m_st, m_own, m_last, m_cnt, m_s;

  mem_port_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .s(s), .busy(busy), .timeout(timeout)
  );

  mem_port_arbiter #(.HOLD_MAX(0), .CNT_W(4)) dut_u (
    .clk(clk), .rst(rst), .req(req_u), .done(done_u),
    .gnt(gnt_u), .s(s_u), .busy(busy_u), .timeout(timeout_u)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_own = 0; m_last = 2; m_cnt = 0; m_s = 0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] d);
    exp_t e;
    bit   to;
    to = 1'b0;
    case (m_st)
      0: if (r != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (r[(m_last + k) % 3]) begin
            m_own = (m_last + k) % 3;
            break;
          end
        end
        m_last = m_own; m_s = m_own; m_cnt = 1; m_st = 1;
      end
      1: begin
        if (d[m_own] || !r[m_own] || m_cnt == M_HOLD) begin
          to   = (m_cnt == M_HOLD) && !d[m_own];
          m_st = 2;
        end else if (m_cnt < 15) begin
          m_cnt++;
        end
      end
      default: m_st = 0;
    endcase
    e.gnt  = (m_st == 1) ? 3'(1 << m_own) : 3'b000;
    e.s    = 2'(m_s);
    e.busy = (m_st == 1);
    e.to   = to;
    sb.push_back(e);
  endtask

  // One clock: drive at negedge, model predicts, compare at next negedge.
  task automatic cyc(input logic [2:0] r, input logic [2:0] d);
    exp_t e;
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    @(negedge clk);
    chk("sb_not_empty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("s", 32'(s), 32'(e.s));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("timeout", 32'(timeout), 32'(e.to));
    end
    chk("s_not_11", 32'(s == 2'b11), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 3'b000; done = 3'b000; req_u = 3'b000; done_u = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [2:0] glog[$];
  int         n_hold, n_to;

  initial begin
    rst = 1'b1; req = 3'b000; done = 3'b000; req_u = 3'b000; done_u = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Single requester 1, release on third grant cycle
    cyc(3'b010, 3'b000);
    chk("single_gnt", 32'(gnt), 32'b010);
    chk("single_s", 32'(s), 32'b01);
    cyc(3'b010, 3'b000);
    cyc(3'b010, 3'b010);
    chk("single_turn_gnt", 32'(gnt), 32'b000);
    chk("single_turn_s", 32'(s), 32'b01);
    cyc(3'b010, 3'b000);
    cyc(3'b010, 3'b000);
    chk("single_regnt", 32'(gnt), 32'b010);

    // Asynchronous reset mid-grant of requester 1
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_s", 32'(s), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(3'b111, 3'b000);
    chk("post_rst_first", 32'(gnt), 32'b001);

    // Round-robin fairness under full load
    do_reset();
    glog.delete();
    for (int i = 0; i < 12; i++) begin
      cyc(3'b111, 3'b111);
      if (gnt != 3'b000) glog.push_back(gnt);
    end
    chk("rr_count", 32'(glog.size()), 32'd4);
    if (glog.size() >= 4) begin
      chk("rr_0", 32'(glog[0]), 32'b001);
      chk("rr_1", 32'(glog[1]), 32'b010);
      chk("rr_2", 32'(glog[2]), 32'b100);
      chk("rr_3", 32'(glog[3]), 32'b001);
    end

    // Hold timeout on requester 2
    do_reset();
    n_hold = 0; n_to = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(3'b100, 3'b000);
      if (gnt == 3'b100) n_hold++;
      if (timeout) n_to++;
    end
    chk("to_hold_len", 32'(n_hold), 32'd8);
    chk("to_pulses", 32'(n_to), 32'd1);
    cyc(3'b100, 3'b000);
    chk("to_regnt", 32'(gnt), 32'b100);
    for (int i = 0; i < 7; i++) cyc(3'b100, 3'b000);
    cyc(3'b100, 3'b100);
    chk("done_at_8_to", 32'(timeout), 32'd0);
    chk("done_at_8_gnt", 32'(gnt), 32'd0);
    cyc(3'b100, 3'b000);

    // Ignored strobes and withdrawal
    do_reset();
    cyc(3'b001, 3'b000);
    cyc(3'b001, 3'b110);
    chk("ignored_done", 32'(gnt), 32'b001);
    cyc(3'b000, 3'b000);
    chk("withdraw_gnt", 32'(gnt), 32'b000);
    chk("withdraw_to", 32'(timeout), 32'd0);
    cyc(3'b000, 3'b000);
    cyc(3'b011, 3'b000);

    // Unlimited hold instance
    do_reset();
    req_u = 3'b001;
    n_to = 0;
    for (int i = 0; i < 41; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (timeout_u) n_to++;
      if (i == 0 || i == 20 || i == 40) begin
        chk("unl_gnt", 32'(gnt_u), 32'b001);
        chk("unl_busy", 32'(busy_u), 32'd1);
      end
    end
    chk("unl_no_timeout", 32'(n_to), 32'd0);
    req_u = 3'b000;
    @(posedge clk);
    @(negedge clk);
    chk("unl_release", 32'(gnt_u), 32'b000);
    chk("unl_release_to", 32'(timeout_u), 32'd0);
    chk("unl_s_hold", 32'(s_u), 32'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
